// File: rtl/branch_predictor_btb_if.sv
// Fetch/decode-side signal bundle of the branch predictor. Port names are
// written from the predictor's point of view (i_ = into predictor, o_ = out of it).
interface branch_predictor_btb_if #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 16
);
  logic [XLEN-1:0]   i_pc_f;
  logic              o_predict_taken;
  logic [XLEN-1:0]   o_predict_target;
  logic              i_stall_d;
  logic              i_flush_d;
  logic              o_pred_taken_d;
  logic [XLEN-1:0]   o_pred_target_d;
  logic              i_upd_valid;
  logic              i_upd_is_branch;
  logic              i_upd_is_jump;
  logic [XLEN-1:0]   i_upd_pc;
  logic              i_upd_taken;
  logic [XLEN-1:0]   i_upd_target;
  logic              i_flush_all;
  logic              o_mispredict;
  logic [XLEN-1:0]   o_redirect_pc;
  logic [STAT_W-1:0] o_branch_cnt;
  logic [STAT_W-1:0] o_mispred_cnt;

  modport master (
    output i_pc_f, i_stall_d, i_flush_d, i_upd_valid, i_upd_is_branch,
           i_upd_is_jump, i_upd_pc, i_upd_taken, i_upd_target, i_flush_all,
    input  o_predict_taken, o_predict_target, o_pred_taken_d, o_pred_target_d,
           o_mispredict, o_redirect_pc, o_branch_cnt, o_mispred_cnt
  );

  modport slave (
    input  i_pc_f, i_stall_d, i_flush_d, i_upd_valid, i_upd_is_branch,
           i_upd_is_jump, i_upd_pc, i_upd_taken, i_upd_target, i_flush_all,
    output o_predict_taken, o_predict_target, o_pred_taken_d, o_pred_target_d,
           o_mispredict, o_redirect_pc, o_branch_cnt, o_mispred_cnt
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating direction counter: predicts in F,
// carries the prediction into D, and flags mispredicts against the D resolution.
module branch_predictor_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_predictor_btb_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

  logic [ENTRIES-1:0] r_valid;
  logic [ENTRIES-1:0] r_jump;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];
  logic [CTR_W-1:0]   r_ctr    [ENTRIES];

  logic              r_pred_taken_d;
  logic [XLEN-1:0]   r_pred_target_d;
  logic [STAT_W-1:0] r_branch_cnt;
  logic [STAT_W-1:0] r_mispred_cnt;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic             w_pred_taken;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic [CTR_W-1:0] w_ctr_next;
  logic             w_mispredict;
  logic [XLEN-1:0]  w_redirect_pc;
  logic             w_unused;

  // Instructions are word aligned, so the two low PC bits carry no information.
  assign w_unused = ^{bus.i_pc_f[1:0], bus.i_upd_pc[1:0]};

  assign w_lk_idx     = bus.i_pc_f[IDX_W+1:2];
  assign w_lk_tag     = bus.i_pc_f[XLEN-1:IDX_W+2];
  assign w_lk_hit     = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_pred_taken = w_lk_hit && (r_ctr[w_lk_idx][CTR_W-1] || r_jump[w_lk_idx]);

  assign bus.o_predict_taken  = w_pred_taken;
  assign bus.o_predict_target = w_pred_taken ? r_target[w_lk_idx] : '0;

  assign w_upd_idx = bus.i_upd_pc[IDX_W+1:2];
  assign w_upd_tag = bus.i_upd_pc[XLEN-1:IDX_W+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  always_comb begin
    w_ctr_next = r_ctr[w_upd_idx];
    if (bus.i_upd_taken && (r_ctr[w_upd_idx] != CTR_MAX))
      w_ctr_next = r_ctr[w_upd_idx] + CTR_W'(1);
    else if (!bus.i_upd_taken && (r_ctr[w_upd_idx] != '0))
      w_ctr_next = r_ctr[w_upd_idx] - CTR_W'(1);
  end

  always_comb begin
    w_mispredict  = 1'b0;
    w_redirect_pc = '0;
    if (bus.i_upd_valid) begin
      if (bus.i_upd_is_branch)
        w_mispredict = (bus.i_upd_taken != r_pred_taken_d) ||
                       (bus.i_upd_taken && (bus.i_upd_target != r_pred_target_d));
      else
        w_mispredict = r_pred_taken_d;
    end
    if (w_mispredict)
      w_redirect_pc = (bus.i_upd_is_branch && bus.i_upd_taken) ? bus.i_upd_target
                                                               : bus.i_upd_pc + XLEN'(4);
  end

  assign bus.o_mispredict  = w_mispredict;
  assign bus.o_redirect_pc = w_redirect_pc;

  // Lookup reads the pre-update contents; writes land at the edge with no bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_jump  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= '0;
      end
    end else if (bus.i_flush_all) begin
      r_valid <= '0;
    end else if (bus.i_upd_valid) begin
      if (bus.i_upd_is_branch) begin
        if (w_upd_hit) begin
          r_ctr[w_upd_idx]  <= w_ctr_next;
          r_jump[w_upd_idx] <= bus.i_upd_is_jump;
          if (bus.i_upd_taken)
            r_target[w_upd_idx] <= bus.i_upd_target;
        end else if (bus.i_upd_taken) begin
          r_valid[w_upd_idx]  <= 1'b1;
          r_tag[w_upd_idx]    <= w_upd_tag;
          r_target[w_upd_idx] <= bus.i_upd_target;
          r_jump[w_upd_idx]   <= bus.i_upd_is_jump;
          r_ctr[w_upd_idx]    <= CTR_WEAK;
        end
      end else if (w_upd_hit) begin
        r_valid[w_upd_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_taken_d  <= 1'b0;
      r_pred_target_d <= '0;
    end else if (bus.i_flush_d) begin
      r_pred_taken_d  <= 1'b0;
      r_pred_target_d <= '0;
    end else if (!bus.i_stall_d) begin
      r_pred_taken_d  <= w_pred_taken;
      r_pred_target_d <= bus.o_predict_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (bus.i_upd_valid && bus.i_upd_is_branch && (r_branch_cnt != '1))
        r_branch_cnt <= r_branch_cnt + STAT_W'(1);
      if (w_mispredict && (r_mispred_cnt != '1))
        r_mispred_cnt <= r_mispred_cnt + STAT_W'(1);
    end
  end

  assign bus.o_pred_taken_d  = r_pred_taken_d;
  assign bus.o_pred_target_d = r_pred_target_d;
  assign bus.o_branch_cnt    = r_branch_cnt;
  assign bus.o_mispred_cnt   = r_mispred_cnt;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb (ENTRIES=16, CTR_W=2): a linear
// sequence of steps with hand-computed expectations checked by immediate asserts.
module tb_branch_predictor_btb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  branch_predictor_btb_if #(.XLEN(32), .STAT_W(16)) bus ();

  branch_predictor_btb #(.XLEN(32), .ENTRIES(16), .CTR_W(2), .STAT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) begin
      $display("  vec %0d %s: 0x%0h", n_vec, tag, obs);
    end else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge so outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic br, input logic taken, input logic jump,
                     input logic [31:0] pc, input logic [31:0] tgt);
    bus.i_upd_valid     = 1'b1;
    bus.i_upd_is_branch = br;
    bus.i_upd_taken     = taken;
    bus.i_upd_is_jump   = jump;
    bus.i_upd_pc        = pc;
    bus.i_upd_target    = tgt;
    #1;
  endtask

  task automatic idle();
    bus.i_upd_valid     = 1'b0;
    bus.i_upd_is_branch = 1'b0;
    bus.i_upd_taken     = 1'b0;
    bus.i_upd_is_jump   = 1'b0;
    bus.i_upd_pc        = '0;
    bus.i_upd_target    = '0;
    #1;
  endtask

  initial begin
    bus.i_pc_f      = 32'h40;
    bus.i_stall_d   = 1'b0;
    bus.i_flush_d   = 1'b0;
    bus.i_flush_all = 1'b0;
    idle();

    // Reset held, then released.
    repeat (3) tick();
    chk("rst_pred_d", bus.o_pred_taken_d, 1'b0);
    chk("rst_bcnt", bus.o_branch_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("init_pt", bus.o_predict_taken, 1'b0);
    chk("init_ptgt", bus.o_predict_target, 32'h0);
    chk("init_misp", bus.o_mispredict, 1'b0);
    chk("init_redir", bus.o_redirect_pc, 32'h0);
    chk("init_bcnt", bus.o_branch_cnt, 16'd0);
    chk("init_mcnt", bus.o_mispred_cnt, 16'd0);

    // Taken branch at 0x40 allocates; lookup in the same cycle still misses.
    upd(1, 1, 0, 32'h40, 32'h100);
    chk("alloc_misp", bus.o_mispredict, 1'b1);
    chk("alloc_redir", bus.o_redirect_pc, 32'h100);
    chk("alloc_nobypass", bus.o_predict_taken, 1'b0);
    tick(); idle();
    chk("hit_pt", bus.o_predict_taken, 1'b1);
    chk("hit_ptgt", bus.o_predict_target, 32'h100);
    chk("hit_bcnt", bus.o_branch_cnt, 16'd1);
    chk("hit_mcnt", bus.o_mispred_cnt, 16'd1);
    chk("hit_pd0", bus.o_pred_taken_d, 1'b0);
    tick();
    chk("d_pt", bus.o_pred_taken_d, 1'b1);
    chk("d_tgt", bus.o_pred_target_d, 32'h100);

    // Correct taken prediction: ctr 2 -> 3.
    upd(1, 1, 0, 32'h40, 32'h100);
    chk("ok_misp", bus.o_mispredict, 1'b0);
    chk("ok_redir", bus.o_redirect_pc, 32'h0);
    tick(); idle();

    // Not-taken run: ctr 3 -> 2 -> 1 -> 0 -> 0.
    upd(1, 0, 0, 32'h40, 32'h0);
    chk("nt1_misp", bus.o_mispredict, 1'b1);
    chk("nt1_redir", bus.o_redirect_pc, 32'h44);
    tick(); idle();
    chk("nt1_pt", bus.o_predict_taken, 1'b1);
    upd(1, 0, 0, 32'h40, 32'h0);
    chk("nt2_misp", bus.o_mispredict, 1'b1);
    tick(); idle();
    chk("nt2_pt", bus.o_predict_taken, 1'b0);
    chk("nt2_pd", bus.o_pred_taken_d, 1'b1);
    upd(1, 0, 0, 32'h40, 32'h0);
    chk("nt3_misp", bus.o_mispredict, 1'b1);
    tick(); idle();
    chk("nt3_pd", bus.o_pred_taken_d, 1'b0);
    upd(1, 0, 0, 32'h40, 32'h0);
    chk("nt4_misp", bus.o_mispredict, 1'b0);
    tick(); idle();
    // A single taken update from a saturated-at-0 counter lands at 1: still not taken.
    upd(1, 1, 0, 32'h40, 32'h100);
    chk("sat_misp", bus.o_mispredict, 1'b1);
    tick(); idle();
    chk("sat_pt", bus.o_predict_taken, 1'b0);
    chk("sat_bcnt", bus.o_branch_cnt, 16'd7);
    chk("sat_mcnt", bus.o_mispred_cnt, 16'd5);

    // 0x80 aliases 0x40 (same index, different tag).
    bus.i_pc_f = 32'h80; #1;
    chk("alias_pt", bus.o_predict_taken, 1'b0);
    upd(1, 1, 0, 32'h80, 32'h200);
    chk("alias_redir", bus.o_redirect_pc, 32'h200);
    tick(); idle();
    chk("alias_hit", bus.o_predict_taken, 1'b1);
    chk("alias_tgt", bus.o_predict_target, 32'h200);
    bus.i_pc_f = 32'h40; #1;
    chk("evict_pt", bus.o_predict_taken, 1'b0);

    // Re-allocate 0x40, let D carry the prediction, then resolve against it.
    upd(1, 1, 0, 32'h40, 32'h100);
    tick(); idle();
    tick();
    chk("d2_pt", bus.o_pred_taken_d, 1'b1);
    chk("d2_tgt", bus.o_pred_target_d, 32'h100);
    upd(1, 0, 0, 32'h40, 32'h0);
    chk("dnt_misp", bus.o_mispredict, 1'b1);
    chk("dnt_redir", bus.o_redirect_pc, 32'h44);
    idle();
    upd(0, 0, 0, 32'h40, 32'h0);
    chk("nb_misp", bus.o_mispredict, 1'b1);
    chk("nb_redir", bus.o_redirect_pc, 32'h44);
    tick(); idle();
    chk("nb_inval", bus.o_predict_taken, 1'b0);
    chk("nb_bcnt", bus.o_branch_cnt, 16'd9);
    chk("nb_mcnt", bus.o_mispred_cnt, 16'd8);

    // Stall holds the D copy; flush wins over stall.
    bus.i_stall_d = 1'b1;
    tick();
    chk("stall_pd", bus.o_pred_taken_d, 1'b1);
    bus.i_flush_d = 1'b1;
    tick();
    chk("flushd_pd", bus.o_pred_taken_d, 1'b0);
    chk("flushd_tgt", bus.o_pred_target_d, 32'h0);
    bus.i_stall_d = 1'b0;
    bus.i_flush_d = 1'b0;

    // flush_all beats a same-cycle allocation; statistics still count.
    upd(1, 1, 0, 32'h40, 32'h100);
    tick(); idle();
    chk("pre_fa_pt", bus.o_predict_taken, 1'b1);
    bus.i_flush_all = 1'b1;
    upd(1, 1, 0, 32'h80, 32'h200);
    tick(); idle();
    bus.i_flush_all = 1'b0; #1;
    chk("fa_pt40", bus.o_predict_taken, 1'b0);
    bus.i_pc_f = 32'h80; #1;
    chk("fa_pt80", bus.o_predict_taken, 1'b0);
    chk("fa_bcnt", bus.o_branch_cnt, 16'd11);
    chk("fa_mcnt", bus.o_mispred_cnt, 16'd10);

    // Jump entry keeps predicting taken after its counter decays to 0.
    bus.i_pc_f = 32'h40;
    upd(1, 1, 1, 32'h40, 32'h300);
    tick(); idle();
    upd(1, 0, 1, 32'h40, 32'h0);
    tick();
    upd(1, 0, 1, 32'h40, 32'h0);
    tick(); idle();
    chk("jmp_pt", bus.o_predict_taken, 1'b1);
    chk("jmp_tgt", bus.o_predict_target, 32'h300);
    tick();
    chk("jmp_pd", bus.o_pred_taken_d, 1'b1);

    // Asynchronous reset mid-update, away from any clock edge.
    upd(1, 1, 0, 32'h80, 32'h200);
    rst_n = 1'b0; #1;
    chk("arst_pd", bus.o_pred_taken_d, 1'b0);
    chk("arst_ptgt_d", bus.o_pred_target_d, 32'h0);
    chk("arst_bcnt", bus.o_branch_cnt, 16'd0);
    chk("arst_mcnt", bus.o_mispred_cnt, 16'd0);
    chk("arst_pt", bus.o_predict_taken, 1'b0);
    tick(); idle();
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_pc_f = 32'h80;
    tick();
    chk("arst_discard", bus.o_predict_taken, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
